aska_arb: RTL and testbench

Two-channel arbiter for the shared stimulation output stage: H-bridge up/down switches and the 6-bit current DAC. Two pulse-generator channels request the stage with level requests. The arbiter grants one at a time with round-robin priority and muxes the winner's switch/DAC controls to the pads through registers. Between grants it enforces a discharge dead time with all switches open. It also guards against over-long pulses and up/down shoot-through. It sits between the channel pulse generators and the top-level `up_switches` / `down_switches` / `DAC` pins.

---
 rtl/aska_arb_if.sv | 35 +++
 rtl/aska_arb.sv | 197 +++++++++++++++++++
 tb/tb_aska_arb.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aska_arb_if.sv
// aska_arb_if: bundle of the channel-side requests and the pad-side outputs
// of the stimulation output-stage arbiter.
//   master : channel pulse generators (drive req/up/down/dac/fault_clr)
//   slave  : the arbiter (drives gnt, pad switches, DAC, busy, fault)
interface aska_arb_if #(
  parameter int SW_W  = 8,
  parameter int DAC_W = 6
);
  logic             req0;
  logic             req1;
  logic [SW_W-1:0]  up0;
  logic [SW_W-1:0]  up1;
  logic [SW_W-1:0]  down0;
  logic [SW_W-1:0]  down1;
  logic [DAC_W-1:0] dac0;
  logic [DAC_W-1:0] dac1;
  logic             fault_clr;
  logic             gnt0;
  logic             gnt1;
  logic [SW_W-1:0]  up_switches;
  logic [SW_W-1:0]  down_switches;
  logic [DAC_W-1:0] DAC;
  logic             busy;
  logic [1:0]       fault;

  modport master (
    output req0, req1, up0, up1, down0, down1, dac0, dac1, fault_clr,
    input  gnt0, gnt1, up_switches, down_switches, DAC, busy, fault
  );

  modport slave (
    input  req0, req1, up0, up1, down0, down1, dac0, dac1, fault_clr,
    output gnt0, gnt1, up_switches, down_switches, DAC, busy, fault
  );
endinterface

// File: rtl/aska_arb.sv
// aska_arb: two-channel round-robin arbiter for the shared H-bridge and
// current DAC. Grants one channel at a time, registers the winner's switch
// and DAC controls to the pads, inserts an all-open dead time between grants,
// releases over-long grants (watchdog) and masks up/down shoot-through bits.
// Ports:
//   clk     : system clock
//   resetn  : asynchronous active-low reset
//   bus     : aska_arb_if.slave -- req/up/down/dac per channel and fault_clr
//             in; gnt0/gnt1, up_switches, down_switches, DAC, busy, fault out
module aska_arb #(
  parameter int SW_W     = 8,
  parameter int DAC_W    = 6,
  parameter int DEAD_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       resetn,
  aska_arb_if.slave  bus
);
  localparam int HW = $clog2(MAX_HOLD);
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [DW-1:0] DEAD_ZERO = DW'(0);
  localparam logic [DW-1:0] DEAD_ONE  = DW'(1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t           state_r, state_n;
  logic [HW-1:0]    hold_r, hold_n;
  logic [DW-1:0]    dead_r, dead_n;
  logic             last_r, last_n;
  logic [1:0]       blk_r, blk_n;
  logic [1:0]       gnt_r, gnt_n;
  logic [SW_W-1:0]  up_r, up_n;
  logic [SW_W-1:0]  down_r, down_n;
  logic [DAC_W-1:0] dac_r, dac_n;
  logic             busy_r, busy_n;
  logic [1:0]       fault_r, fault_n;

  logic [1:0]       req_s;
  logic [1:0]       elig_s;
  logic             arb_ok_s;
  logic             arb_ch_s;
  logic             ld_ch_s;
  logic             load_s;
  logic [1:0]       fault_set_s;
  logic [SW_W-1:0]  up_sel_s;
  logic [SW_W-1:0]  down_sel_s;
  logic [DAC_W-1:0] dac_sel_s;
  logic [SW_W-1:0]  shoot_s;

  assign req_s = {bus.req1, bus.req0};

  // Arbitration winner and input mux for the channel whose controls load now.
  always_comb begin
    elig_s   = req_s & ~blk_r;
    arb_ok_s = |elig_s;
    if (elig_s == 2'b11) begin
      arb_ch_s = ~last_r;          // tie: the channel not served last
    end else if (elig_s == 2'b10) begin
      arb_ch_s = 1'b1;
    end else begin
      arb_ch_s = 1'b0;
    end
    // While granted, `last_r` is the owner; otherwise a load is a fresh grant.
    if (state_r == ST_GRANT) begin
      ld_ch_s = last_r;
    end else begin
      ld_ch_s = arb_ch_s;
    end
    if (ld_ch_s) begin
      up_sel_s   = bus.up1;
      down_sel_s = bus.down1;
      dac_sel_s  = bus.dac1;
    end else begin
      up_sel_s   = bus.up0;
      down_sel_s = bus.down0;
      dac_sel_s  = bus.dac0;
    end
    shoot_s = up_sel_s & down_sel_s;
  end

  // Next state, counters, block flags and next pad values.
  always_comb begin
    state_n     = state_r;
    hold_n      = hold_r;
    dead_n      = dead_r;
    last_n      = last_r;
    blk_n       = blk_r & req_s;   // a low request clears its block
    load_s      = 1'b0;
    fault_set_s = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (arb_ok_s) begin
          state_n = ST_GRANT;
          last_n  = arb_ch_s;
          hold_n  = HOLD_ZERO;
          load_s  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req_s[last_r]) begin
          state_n = ST_DEAD;
          dead_n  = DEAD_LOAD;
        end else if (hold_r == HOLD_LAST) begin
          // Watchdog: channel stays blocked until it drops its request.
          state_n        = ST_DEAD;
          dead_n         = DEAD_LOAD;
          fault_set_s[0] = 1'b1;
          blk_n[last_r]  = 1'b1;
        end else begin
          hold_n = hold_r + HOLD_ONE;
          load_s = 1'b1;
        end
      end
      ST_DEAD: begin
        if (dead_r != DEAD_ZERO) begin
          dead_n = dead_r - DEAD_ONE;
        end else if (arb_ok_s) begin
          state_n = ST_GRANT;
          last_n  = arb_ch_s;
          hold_n  = HOLD_ZERO;
          load_s  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (load_s) begin
      gnt_n          = ld_ch_s ? 2'b10 : 2'b01;
      up_n           = up_sel_s & ~shoot_s;
      down_n         = down_sel_s & ~shoot_s;
      dac_n          = dac_sel_s;
      fault_set_s[1] = |shoot_s;
    end else begin
      gnt_n  = 2'b00;
      up_n   = {SW_W{1'b0}};
      down_n = {SW_W{1'b0}};
      dac_n  = {DAC_W{1'b0}};
    end

    busy_n  = (state_n != ST_IDLE);
    // A set on the same edge as a clear wins for that bit.
    fault_n = (fault_r & ~{2{bus.fault_clr}}) | fault_set_s;
  end

  // State, counters and registered pad outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      hold_r  <= HOLD_ZERO;
      dead_r  <= DEAD_ZERO;
      last_r  <= 1'b1;
      blk_r   <= 2'b00;
      gnt_r   <= 2'b00;
      up_r    <= {SW_W{1'b0}};
      down_r  <= {SW_W{1'b0}};
      dac_r   <= {DAC_W{1'b0}};
      busy_r  <= 1'b0;
      fault_r <= 2'b00;
    end else begin
      state_r <= state_n;
      hold_r  <= hold_n;
      dead_r  <= dead_n;
      last_r  <= last_n;
      blk_r   <= blk_n;
      gnt_r   <= gnt_n;
      up_r    <= up_n;
      down_r  <= down_n;
      dac_r   <= dac_n;
      busy_r  <= busy_n;
      fault_r <= fault_n;
    end
  end

  assign bus.gnt0          = gnt_r[0];
  assign bus.gnt1          = gnt_r[1];
  assign bus.up_switches   = up_r;
  assign bus.down_switches = down_r;
  assign bus.DAC           = dac_r;
  assign bus.busy          = busy_r;
  assign bus.fault         = fault_r;
endmodule

// File: tb/tb_aska_arb.sv
// tb_aska_arb: directed scenarios plus randomized traffic for aska_arb,
// checked every cycle against a behavioural model of owner / dead-gap /
// block / fault rules, with literal expectations at key points.
module tb_aska_arb;
  localparam int SW_W     = 8;
  localparam int DAC_W    = 6;
  localparam int DEAD_CYC = 2;
  localparam int MAX_HOLD = 16;

  logic clk;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  aska_arb_if #(.SW_W(SW_W), .DAC_W(DAC_W)) bus ();

  aska_arb #(
    .SW_W(SW_W), .DAC_W(DAC_W), .DEAD_CYC(DEAD_CYC), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int               m_owner;   // -1 when nobody holds the stage
  int               m_held;    // cycles the owner has been granted so far
  int               m_gap;     // dead cycles still to elapse (0 = idle)
  int               m_last;
  logic [1:0]       m_blk;
  logic [1:0]       m_fault;
  logic [1:0]       e_gnt;
  logic [SW_W-1:0]  e_up;
  logic [SW_W-1:0]  e_dn;
  logic [DAC_W-1:0] e_dac;
  logic             e_busy;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = 1;
    m_blk = 2'b00; m_fault = 2'b00; e_gnt = 2'b00;
    e_up = '0; e_dn = '0; e_dac = '0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0]      req, elig, nblk, fs;
    logic [SW_W-1:0] u, d, ov;
    int              pick;
    req  = {bus.req1, bus.req0};
    nblk = m_blk & req;
    fs   = 2'b00;
    pick = -1;
    e_gnt = 2'b00; e_up = '0; e_dn = '0; e_dac = '0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_gap = DEAD_CYC;
      end else if (m_held == MAX_HOLD) begin
        fs[0] = 1'b1; nblk[m_owner] = 1'b1;
        m_owner = -1; m_gap = DEAD_CYC;
      end else begin
        m_held++; pick = m_owner;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      elig  = req & ~m_blk;
      m_gap = 0;
      if (elig == 2'b11) pick = 1 - m_last;
      else if (elig == 2'b01) pick = 0;
      else if (elig == 2'b10) pick = 1;
      if (pick >= 0) begin
        m_owner = pick; m_held = 1; m_last = pick;
      end
    end
    if (pick >= 0) begin
      u  = (pick == 1) ? bus.up1 : bus.up0;
      d  = (pick == 1) ? bus.down1 : bus.down0;
      ov = u & d;
      e_up  = u & ~ov;
      e_dn  = d & ~ov;
      e_dac = (pick == 1) ? bus.dac1 : bus.dac0;
      e_gnt = (pick == 1) ? 2'b10 : 2'b01;
      if (ov != '0) fs[1] = 1'b1;
    end
    m_fault = (bus.fault_clr ? 2'b00 : m_fault) | fs;
    m_blk   = nblk;
    e_busy  = (m_owner >= 0) || (m_gap > 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [1:0] prev_gnt = 2'b00;
  initial begin
    forever begin
      @(negedge clk);
      chk("gnt",   {30'd0, bus.gnt1, bus.gnt0}, {30'd0, e_gnt});
      chk("up",    {24'd0, bus.up_switches},    {24'd0, e_up});
      chk("down",  {24'd0, bus.down_switches},  {24'd0, e_dn});
      chk("dac",   {26'd0, bus.DAC},            {26'd0, e_dac});
      chk("busy",  {31'd0, bus.busy},           {31'd0, e_busy});
      chk("fault", {30'd0, bus.fault},          {30'd0, m_fault});
      chk("bbm", {31'd0, (bus.gnt0 & bus.gnt1) | (bus.gnt0 & prev_gnt[1]) | (bus.gnt1 & prev_gnt[0])}, 32'd0);
      prev_gnt = {bus.gnt1, bus.gnt0};
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.up0 = 8'h00; bus.up1 = 8'h00; bus.down0 = 8'h00; bus.down1 = 8'h00;
    bus.dac0 = 6'd0; bus.dac1 = 6'd0; bus.fault_clr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    tick(3);
    chk("rst_outs", {bus.gnt1, bus.gnt0, bus.up_switches, bus.down_switches, bus.DAC, bus.busy, bus.fault}, 32'd0);
    resetn = 1'b1;
    tick(2);

    // Simultaneous requests, each held 3 cycles after its grant.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick(1); chk("tie_first_gnt0", {bus.gnt1, bus.gnt0}, 32'd1);
    tick(2); chk("tie_gnt0_c3",    {bus.gnt1, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0;
    tick(1); chk("tie_dead1", {bus.gnt1, bus.gnt0}, 32'd0);
    tick(1); chk("tie_dead2", {bus.gnt1, bus.gnt0}, 32'd0);
    tick(1); chk("tie_gnt1",  {bus.gnt1, bus.gnt0}, 32'd2);
    tick(2);
    bus.req1 = 1'b0;
    tick(3);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick(1); chk("tie_next_gnt0", {bus.gnt1, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(4);

    // Single request, 5 cycles.
    bus.req0 = 1'b1; bus.up0 = 8'h01; bus.down0 = 8'h02; bus.dac0 = 6'd20;
    tick(1);
    chk("single_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("single_up",   {24'd0, bus.up_switches}, 32'h01);
    chk("single_down", {24'd0, bus.down_switches}, 32'h02);
    chk("single_dac",  {26'd0, bus.DAC}, 32'd20);
    tick(4);
    bus.req0 = 1'b0;
    tick(1);
    chk("single_rel", {bus.gnt1, bus.gnt0, bus.up_switches, bus.down_switches, bus.DAC}, 32'd0);
    chk("single_busy1", {31'd0, bus.busy}, 32'd1);
    tick(1); chk("single_busy2", {31'd0, bus.busy}, 32'd1);
    tick(1); chk("single_busy3", {31'd0, bus.busy}, 32'd0);
    clear_inputs();
    tick(1);

    // Watchdog: req1 held 30 cycles.
    bus.req1 = 1'b1; bus.up1 = 8'hF0; bus.down1 = 8'h0F; bus.dac1 = 6'd33;
    tick(1);  chk("wd_gnt",   {31'd0, bus.gnt1}, 32'd1);
    tick(15); chk("wd_hold",  {31'd0, bus.gnt1}, 32'd1);
    tick(1);  chk("wd_drop",  {31'd0, bus.gnt1}, 32'd0);
    chk("wd_fault", {30'd0, bus.fault}, 32'd1);
    tick(13); chk("wd_noregrant", {31'd0, bus.gnt1}, 32'd0);
    bus.req1 = 1'b0;
    tick(1);
    bus.req1 = 1'b1;
    tick(1);  chk("wd_regrant", {31'd0, bus.gnt1}, 32'd1);
    bus.req1 = 1'b0;
    tick(1);
    bus.fault_clr = 1'b1;
    tick(1);  chk("wd_clr", {30'd0, bus.fault}, 32'd0);
    bus.fault_clr = 1'b0;
    clear_inputs();
    tick(3);

    // Shoot-through guard.
    bus.req0 = 1'b1; bus.up0 = 8'h0C; bus.down0 = 8'h04; bus.dac0 = 6'd7;
    tick(1);
    chk("st_up",    {24'd0, bus.up_switches}, 32'h08);
    chk("st_down",  {24'd0, bus.down_switches}, 32'h00);
    chk("st_fault", {30'd0, bus.fault}, 32'd2);
    chk("st_dac",   {26'd0, bus.DAC}, 32'd7);
    tick(1);
    clear_inputs();
    tick(4);

    // Waiting requester.
    bus.req0 = 1'b1; bus.up0 = 8'h11; bus.down0 = 8'h22; bus.dac0 = 6'd5;
    bus.up1 = 8'h40; bus.down1 = 8'h80; bus.dac1 = 6'd9;
    tick(2);
    bus.req1 = 1'b1;
    tick(2);
    bus.req0 = 1'b0;
    tick(1); chk("wait_g0_fall", {bus.gnt1, bus.gnt0}, 32'd0);
    tick(1); chk("wait_dead",    {bus.gnt1, bus.gnt0}, 32'd0);
    tick(1); chk("wait_g1_rise", {bus.gnt1, bus.gnt0}, 32'd2);
    chk("wait_up1", {24'd0, bus.up_switches}, 32'h40);
    bus.req1 = 1'b0;
    tick(4);

    // Reset mid-GRANT, then first tie goes to channel 0.
    bus.req0 = 1'b1; bus.up0 = 8'h55; bus.down0 = 8'h0A; bus.dac0 = 6'd31;
    tick(2);
    chk("mid_nonzero", {31'd0, bus.gnt0}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk("mid_async", {bus.gnt1, bus.gnt0, bus.up_switches, bus.down_switches, bus.DAC, bus.busy, bus.fault}, 32'd0);
    clear_inputs();
    tick(1);
    resetn = 1'b1;
    tick(1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick(1); chk("post_rst_tie", {bus.gnt1, bus.gnt0}, 32'd1);
    clear_inputs();
    tick(4);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.req0 = ~bus.req0;
      if ($urandom_range(0, 7) == 0) bus.req1 = ~bus.req1;
      bus.up0   = 8'($urandom);
      bus.down0 = 8'($urandom) & 8'($urandom);
      bus.up1   = 8'($urandom);
      bus.down1 = 8'($urandom) & 8'($urandom);
      bus.dac0  = 6'($urandom);
      bus.dac1  = 6'($urandom);
      bus.fault_clr = ($urandom_range(0, 15) == 0);
      tick(1);
    end

    clear_inputs();
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
